if_stall_hold: RTL

- Consumer side of the fetch-stall "choice flag" scheme: owns the latched-register (lr) copy of the instruction-memory read data and decides, cycle by cycle, whether decode sees live memory output or the held lr value.
- Internally generates the choice flag (1 cycle after stall rises, until 1 cycle after stall falls) and drives the muxed instruction/PC/valid into the IF/ID stage.
- Applies flush as a NOP bubble and keeps a saturating stall-cycle perf counter.

---
 rtl/if_stall_hold.sv | 125 ++++++++++++
 1 files changed

// File: rtl/if_stall_hold.sv
// if_stall_hold
//   Consumer side of the fetch-stall choice-flag scheme. It keeps a latched
//   copy (lr) of the synchronous instruction-memory output and selects, each
//   cycle, whether IF/ID sees live memory data (PASS) or the held copy (HOLD).
//   A flush inserts a NOP bubble. A saturating counter records HOLD cycles.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   stall_i         stall request from hazard unit
//   flush_i         branch/jump flush, wins over stall_i
//   mem_rdata_i     ROM read data for the address issued last cycle
//   mem_pc_i        PC of mem_rdata_i
//   mem_valid_i     mem_rdata_i is a real fetch
//   inst_o          instruction to IF/ID
//   inst_pc_o       PC of inst_o
//   inst_valid_o    inst_o is valid
//   choice_flag_o   1 = outputs come from lr, 0 = live memory
//   stall_cnt_o     saturating count of HOLD cycles with stall asserted

module if_stall_hold #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  input  logic [XLEN-1:0]  mem_pc_i,
  input  logic             mem_valid_i,
  output logic [XLEN-1:0]  inst_o,
  output logic [XLEN-1:0]  inst_pc_o,
  output logic             inst_valid_o,
  output logic             choice_flag_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            vld;
  } fetch_t;

  typedef enum logic {PASS = 1'b0, HOLD = 1'b1} state_t;

  state_t     state, state_nxt;
  fetch_t     live, lr, src;
  logic       capture;
  logic [CNT_W-1:0] stall_cnt;

  assign live = '{inst: mem_rdata_i, pc: mem_pc_i, vld: mem_valid_i};

  // Capture only on the PASS->HOLD transition so lr stays stable for the
  // whole stall no matter how the live bus wanders.
  assign capture = (state == PASS) && stall_i && !flush_i;

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PASS;
    else     state <= state_nxt;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = PASS;
    end else begin
      case (state)
        PASS:    state_nxt = stall_i ? HOLD : PASS;
        HOLD:    state_nxt = stall_i ? HOLD : PASS;
        default: state_nxt = PASS;
      endcase
    end
  end

  // ---------------- latched fetch copy ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr <= '{inst: NOP_INST, pc: RESET_PC, vld: 1'b0};
    end else if (flush_i) begin
      // PC left as-is; only the instruction is squashed.
      lr.inst <= NOP_INST;
      lr.vld  <= 1'b0;
    end else if (capture) begin
      lr <= live;
    end
  end

  // ---------------- stall-cycle counter ----------------
  // Counts HOLD cycles in which the stall persists; the release cycle and
  // flushed cycles are not stall time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if ((state == HOLD) && stall_i && !flush_i && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign stall_cnt_o = stall_cnt;

  // ---------------- outputs ----------------
  // rst is folded in combinationally so outputs drop to reset values the
  // moment reset asserts, even though PASS is otherwise a live pass-through.
  always_comb begin
    src           = (state == HOLD) ? lr : live;
    inst_o        = src.inst;
    inst_pc_o     = src.pc;
    inst_valid_o  = src.vld;
    choice_flag_o = (state == HOLD);
    if (flush_i) begin
      inst_o       = NOP_INST;
      inst_valid_o = 1'b0;
    end
    if (rst) begin
      inst_o        = NOP_INST;
      inst_pc_o     = RESET_PC;
      inst_valid_o  = 1'b0;
      choice_flag_o = 1'b0;
    end
  end

endmodule
